muldiv_w: RTL and testbench
===========================

# muldiv_w

Parametrised multiply/divide unit for the CPU execute stage, driving the HI/LO register pair. Adds to the previous generation: configurable width, signed/unsigned selection per operation, multiply-subtract, a configurable multiply pipeline depth, and signed restoring division with defined divide-by-zero and overflow results. The pipeline stalls on BUSY; results are read through HI/LO.

## Interface
- W, 32: operand and HI/LO width, ≥4, power of two.
- MUL_LAT, 1: registered multiply stages, 1..3.
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- EN  in  1  operation request; accepted only when BUSY=0.
- OP  in  3  0=MUL, 1=MADD, 2=MSUB, 3=DIV, 4=MTLO, 5=MTHI, 6/7 reserved (no-op).
- SGN  in  1  1=signed operands (MUL/MADD/MSUB/DIV); ignored for MT*.
- A  in  W  multiplicand / dividend / MT data.
- B  in  W  multiplier / divisor.
- HI  out  W  high word / remainder; reset 0.
- LO  out  W  low word / quotient; reset 0.
- BUSY  out  1  operation in flight; reset 0.
- DIV0  out  1  sticky divide-by-zero flag; reset 0 (only with MULDIV_DIVZERO_EN).

## Operation
- Accept edge: rising edge with EN=1, BUSY=0. EN while BUSY=1 is ignored; no queueing.
- MUL: {HI,LO} = A*B, 2W-bit. Signed or unsigned per SGN.
- MADD/MSUB: {HI,LO} = {HI,LO} ± A*B, mod 2^(2W). Uses the HI/LO value at the write edge.
- MTLO/MTHI: writes A into LO or HI at the accept edge. The other word is unchanged. BUSY stays 0.
- DIV, unsigned: radix-2 restoring division, one quotient bit per cycle.
  - Quotient goes to LO, remainder to HI.
- DIV, signed: operands are converted to magnitudes at acceptance.
  - The quotient is negated if the signs differ.
  - The remainder takes the sign of the dividend.
  - Most-negative / -1: LO = most-negative (wrap), HI = 0.
- Divide by zero, any SGN: HI = A, LO = all-ones.
- Operands, SGN and OP are latched at the accept edge. Inputs may change freely afterwards.
- Reserved OP: no state change, BUSY stays 0.

## Timing
- Edge 0 is the accept edge.
- MUL/MADD/MSUB:
  - BUSY=1 after edge 0 through edge MUL_LAT.
  - HI/LO are written at edge MUL_LAT, and BUSY falls at the same edge.
  - MUL_LAT=1 gives one BUSY cycle.
- DIV:
  - BUSY=1 after edge 0.
  - Iteration edges are 1..W.
  - Sign correction and the HI/LO write happen at edge W+1, where BUSY falls.
  - Total W+1 BUSY cycles.
  - A new op may be accepted at the edge after BUSY falls.
- MT*: HI/LO change at edge 0.
- HI/LO hold their value between writes. They are never partially updated.
- RESET asserted at any time, including mid-divide or mid-multiply:
  - HI, LO, BUSY, DIV0 and all internal state clear immediately.
  - The in-flight operation is discarded.
- Iteration counter: C = log2(W)+1 bits, so W is representable. It clears on acceptance.

## Configuration
- MULDIV_DIVZERO_EN defined:
  - A DIV with B=0 completes at edge 1, with BUSY high for one cycle and result HI=A, LO=all-ones.
  - DIV0 is set at the same edge. It is cleared by RESET or by any accepted DIV with B≠0.
- Not defined:
  - The DIV0 port is absent.
  - B=0 runs the full W+1 cycles and produces the same HI=A, LO=all-ones result.

## Structure
- Package muldiv_pkg:
  - op_e enum for OP (MUL, MADD, MSUB, DIV, MTLO, MTHI).
  - Localparams for the reserved codes.
  - log2 function.
- Sub-module muldiv_div_core (W):
  - Unsigned restoring divider with GO, DONE, A, B, QUOT, REM.
  - Sign handling stays in the top.
- The multiply pipeline is a shift chain of MUL_LAT product registers in the top, tagged with op and valid.

## Test plan
- W=32, MUL_LAT=1, SGN=1, MUL A=-3, B=7 -> after edge 1: HI=FFFFFFFF, LO=FFFFFFEB; BUSY high exactly 1 cycle.
- MTHI 1, MTLO 0, then MADD SGN=0 A=FFFFFFFF B=2 -> HI=00000002, LO=FFFFFFFE; then MSUB SGN=0 same operands -> HI=00000001, LO=00000000.
- DIV SGN=1 A=-7 B=2 -> LO=FFFFFFFD, HI=FFFFFFFF; BUSY high 33 cycles. The same operands with SGN=0 -> LO=7FFFFFFC, HI=00000001.
- DIV SGN=1 A=80000000 B=FFFFFFFF -> LO=80000000, HI=0. DIV B=0 A=1234 -> HI=1234, LO=FFFFFFFF; with MULDIV_DIVZERO_EN, BUSY is 1 cycle and DIV0=1.
- Assert RESET at iteration 10 of a DIV -> HI=LO=0 and BUSY=0 immediately. EN pulsed during BUSY -> ignored, result unchanged.
- MUL_LAT=3, W=16, MUL SGN=0 A=FFFF B=FFFF -> HI=FFFE, LO=0001 written at edge 3; BUSY high 3 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
//==============================================================================
// Module  : muldiv_pkg
// Brief   : Shared opcode encoding and helpers for the muldiv_w unit.
// Revision: 1.0
//==============================================================================
`default_nettype none

package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL  = 3'd0,
        OP_MADD = 3'd1,
        OP_MSUB = 3'd2,
        OP_DIV  = 3'd3,
        OP_MTLO = 3'd4,
        OP_MTHI = 3'd5
    } op_e;

    localparam logic [2:0] OP_RSV6 = 3'd6;
    localparam logic [2:0] OP_RSV7 = 3'd7;

    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 30; i++) begin
            if ((1 << (i + 1)) <= v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_div_core.sv
//==============================================================================
// Module  : muldiv_div_core
// Brief   : Unsigned radix-2 restoring divider, one quotient bit per cycle.
// Revision: 1.0
//==============================================================================
`default_nettype none

module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic         busy,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);

    localparam int             C        = log2(W) + 1;
    localparam logic [C-1:0]   CNT_LAST = C'(W);

    logic [C-1:0] r_cnt;
    logic         r_busy;
    logic [W-1:0] r_rem;
    logic [W-1:0] r_quot;
    logic [W-1:0] r_div;
    logic [W:0]   w_sh;
    logic [W:0]   w_diff;

    // Partial remainder shifted left with the next dividend bit; the sign of
    // the trial subtraction decides the quotient bit.
    assign w_sh   = {r_rem, r_quot[W-1]};
    assign w_diff = w_sh - {1'b0, r_div};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quot <= '0;
            r_div  <= '0;
        end else if (go) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quot <= a;
            r_div  <= b;
        end else if (r_busy) begin
            if (r_cnt == CNT_LAST) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_rem  <= w_diff[W] ? w_sh[W-1:0] : w_diff[W-1:0];
                r_quot <= {r_quot[W-2:0], ~w_diff[W]};
            end
        end
    end

    assign done = r_busy && (r_cnt == CNT_LAST);
    assign busy = r_busy;
    assign quot = r_quot;
    assign rem  = r_rem;

endmodule

`default_nettype wire

// File: rtl/muldiv_w.sv
//==============================================================================
// Module  : muldiv_w
// Brief   : Multiply/divide unit driving HI/LO; MUL/MADD/MSUB/DIV/MTLO/MTHI.
//           MULDIV_DIVZERO_EN: fast divide-by-zero with sticky div0 flag.
// Revision: 1.0
//==============================================================================
`default_nettype none

module muldiv_w
    import muldiv_pkg::*;
#(
    parameter int W       = 32,
    parameter int MUL_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [2:0]   op,
    input  logic         sgn,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy
`ifdef MULDIV_DIVZERO_EN
    ,
    output logic         div0
`endif
);

    logic           w_acc;
    logic           w_is_rsv;
    logic           w_is_mul;
    logic           w_start_div;
    logic           w_bzero;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic [2*W-1:0] w_a_ext;
    logic [2*W-1:0] w_b_ext;
    logic [2*W-1:0] w_prod;
    logic           w_dz_go;
    logic           w_core_go;
    logic           w_core_done;
    logic           w_core_busy;
    logic [W-1:0]   w_quot;
    logic [W-1:0]   w_rem;
    logic [W-1:0]   w_q_fix;
    logic [W-1:0]   w_r_fix;

    logic           r_neg_q;
    logic           r_neg_r;
    logic           r_bzero;
    logic [W-1:0]   r_a_raw;
    logic           r_dz_pend;

    logic [2*W-1:0] r_prod [MUL_LAT];
    op_e            r_mop  [MUL_LAT];
    logic [MUL_LAT-1:0] r_mvld;

    assign w_is_rsv    = (op == OP_RSV6) || (op == OP_RSV7);
    assign w_acc       = en && !busy && !w_is_rsv;
    assign w_is_mul    = (op == OP_MUL) || (op == OP_MADD) || (op == OP_MSUB);
    assign w_start_div = w_acc && (op == OP_DIV);
    assign w_bzero     = (b == '0);

    assign w_a_neg = sgn && a[W-1];
    assign w_b_neg = sgn && b[W-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // Extending to 2W bits makes the low 2W product bits correct for both modes.
    assign w_a_ext = {{W{w_a_neg}}, a};
    assign w_b_ext = {{W{w_b_neg}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

`ifdef MULDIV_DIVZERO_EN
    assign w_dz_go = w_start_div && w_bzero;
`else
    assign w_dz_go = 1'b0;
`endif
    assign w_core_go = w_start_div && !w_dz_go;

    muldiv_div_core #(
        .W(W)
    ) u_div_core (
        .clk   (clk),
        .reset (reset),
        .go    (w_core_go),
        .a     (w_a_mag),
        .b     (w_b_mag),
        .done  (w_core_done),
        .busy  (w_core_busy),
        .quot  (w_quot),
        .rem   (w_rem)
    );

    assign w_q_fix = r_neg_q ? -w_quot : w_quot;
    assign w_r_fix = r_neg_r ? -w_rem  : w_rem;

    assign busy = (|r_mvld) || w_core_busy || r_dz_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_bzero   <= 1'b0;
            r_a_raw   <= '0;
            r_dz_pend <= 1'b0;
        end else begin
            r_dz_pend <= w_dz_go;
            if (w_start_div) begin
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_bzero <= w_bzero;
                r_a_raw <= a;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mvld <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                r_prod[i] <= '0;
                r_mop[i]  <= OP_MUL;
            end
        end else begin
            r_mvld[0] <= w_acc && w_is_mul;
            if (w_acc && w_is_mul) begin
                r_prod[0] <= w_prod;
                r_mop[0]  <= op_e'(op);
            end
            for (int i = 1; i < MUL_LAT; i++) begin
                r_mvld[i] <= r_mvld[i-1];
                r_prod[i] <= r_prod[i-1];
                r_mop[i]  <= r_mop[i-1];
            end
        end
    end

    // Writers are mutually exclusive because every multi-cycle op holds busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (r_mvld[MUL_LAT-1]) begin
            case (r_mop[MUL_LAT-1])
                OP_MADD: {hi, lo} <= {hi, lo} + r_prod[MUL_LAT-1];
                OP_MSUB: {hi, lo} <= {hi, lo} - r_prod[MUL_LAT-1];
                default: {hi, lo} <= r_prod[MUL_LAT-1];
            endcase
        end else if (w_core_done) begin
            if (r_bzero) begin
                hi <= r_a_raw;
                lo <= '1;
            end else begin
                hi <= w_r_fix;
                lo <= w_q_fix;
            end
        end else if (r_dz_pend) begin
            hi <= r_a_raw;
            lo <= '1;
        end else if (w_acc && (op == OP_MTLO)) begin
            lo <= a;
        end else if (w_acc && (op == OP_MTHI)) begin
            hi <= a;
        end
    end

`ifdef MULDIV_DIVZERO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div0 <= 1'b0;
        end else if (r_dz_pend) begin
            div0 <= 1'b1;
        end else if (w_start_div && !w_bzero) begin
            div0 <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_muldiv_w.sv
//==============================================================================
// Module  : tb_muldiv_w
// Brief   : Directed self-checking bench for muldiv_w (W=32/L=1 and W=16/L=3).
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_muldiv_w;
    import muldiv_pkg::*;

`ifdef MULDIV_DIVZERO_EN
    localparam int DZ_CYC = 1;
`else
    localparam int DZ_CYC = 33;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        en, sgn, busy;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        en2, sgn2, busy2;
    logic [2:0]  op2;
    logic [15:0] a2, b2, hi2, lo2;
`ifdef MULDIV_DIVZERO_EN
    logic        div0, div0_2;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    always #5 clk = ~clk;

    muldiv_w #(.W(32), .MUL_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .sgn(sgn),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy)
`ifdef MULDIV_DIVZERO_EN
        , .div0(div0)
`endif
    );

    muldiv_w #(.W(16), .MUL_LAT(3)) u_dut2 (
        .clk(clk), .reset(reset), .en(en2), .op(op2), .sgn(sgn2),
        .a(a2), .b(b2), .hi(hi2), .lo(lo2), .busy(busy2)
`ifdef MULDIV_DIVZERO_EN
        , .div0(div0_2)
`endif
    );

    task automatic issue(input logic [2:0] o, input logic s,
                         input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        en = 1'b1; op = o; sgn = s; a = x; b = y;
        @(posedge clk);
        #1;
        en = 1'b0; op = 3'($urandom); sgn = 1'($urandom);
        a = $urandom; b = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 0; op = 0; sgn = 0; a = 0; b = 0;
        en2 = 0; op2 = 0; sgn2 = 0; a2 = 0; b2 = 0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_tests++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (busy2 !== 1'b0 || hi2 !== 16'h0 || lo2 !== 16'h0) begin
            n_fail++; $display("FAIL reset_dut2: got %b %h %h want 0 0000 0000", busy2, hi2, lo2); end
`ifdef MULDIV_DIVZERO_EN
        n_tests++; if (div0 !== 1'b0) begin n_fail++; $display("FAIL reset_div0: got %b want 0", div0); end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mul;
        issue(OP_MUL, 1'b1, 32'hFFFFFFFD, 32'd7);
        wait_idle(cyc);
        n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 1", cyc); end
        n_tests++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mul_s_hi: got %h want FFFFFFFF", hi); end
        n_tests++; if (lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_s_lo: got %h want FFFFFFEB", lo); end
        issue(OP_MUL, 1'b0, 32'hFFFFFFFD, 32'd7);
        wait_idle(cyc);
        n_tests++; if ({hi, lo} !== 64'h00000006_FFFFFFEB) begin
            n_fail++; $display("FAIL mul_u: got %h want 00000006FFFFFFEB", {hi, lo}); end
    endtask

    task automatic test_madd_msub;
        issue(OP_MTHI, 1'b0, 32'd1, 32'd0);
        n_tests++; if (hi !== 32'd1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mthi: got hi=%h busy=%b want 00000001 0", hi, busy); end
        issue(OP_MTLO, 1'b0, 32'd0, 32'd0);
        n_tests++; if ({hi, lo} !== 64'h00000001_00000000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mtlo: got %h busy=%b want 0000000100000000 0", {hi, lo}, busy); end
        issue(OP_MADD, 1'b0, 32'hFFFFFFFF, 32'd2);
        wait_idle(cyc);
        n_tests++; if ({hi, lo} !== 64'h00000002_FFFFFFFE) begin
            n_fail++; $display("FAIL madd: got %h want 00000002FFFFFFFE", {hi, lo}); end
        issue(OP_MSUB, 1'b0, 32'hFFFFFFFF, 32'd2);
        wait_idle(cyc);
        n_tests++; if ({hi, lo} !== 64'h00000001_00000000) begin
            n_fail++; $display("FAIL msub: got %h want 0000000100000000", {hi, lo}); end
    endtask

    task automatic test_div;
        issue(OP_DIV, 1'b1, 32'hFFFFFFF9, 32'd2);
        repeat (5) begin @(posedge clk); #1; end
        n_tests++; if ({hi, lo} !== 64'h00000001_00000000 || busy !== 1'b1) begin
            n_fail++; $display("FAIL div_hold: got %h busy=%b want 0000000100000000 1", {hi, lo}, busy); end
        wait_idle(cyc);
        n_tests++; if (cyc + 5 !== 33) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 33", cyc + 5); end
        n_tests++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_s_lo: got %h want FFFFFFFD", lo); end
        n_tests++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_s_hi: got %h want FFFFFFFF", hi); end
        issue(OP_DIV, 1'b0, 32'hFFFFFFF9, 32'd2);
        wait_idle(cyc);
        n_tests++; if ({hi, lo} !== 64'h00000001_7FFFFFFC) begin
            n_fail++; $display("FAIL div_u: got %h want 000000017FFFFFFC", {hi, lo}); end
        issue(OP_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(cyc);
        n_tests++; if ({hi, lo} !== 64'h00000000_80000000) begin
            n_fail++; $display("FAIL div_ovf: got %h want 0000000080000000", {hi, lo}); end
        issue(OP_DIV, 1'b1, 32'hFFFFFF9C, 32'd7);
        wait_idle(cyc);
        n_tests++; if ({hi, lo} !== 64'hFFFFFFFE_FFFFFFF2) begin
            n_fail++; $display("FAIL div_s_neg_dividend: got %h want FFFFFFFEFFFFFFF2", {hi, lo}); end
    endtask

    task automatic test_divzero;
        issue(OP_DIV, 1'b0, 32'h00001234, 32'd0);
        wait_idle(cyc);
        n_tests++; if (cyc !== DZ_CYC) begin n_fail++; $display("FAIL div0_busy_cycles: got %0d want %0d", cyc, DZ_CYC); end
        n_tests++; if ({hi, lo} !== 64'h00001234_FFFFFFFF) begin
            n_fail++; $display("FAIL div0_u: got %h want 00001234FFFFFFFF", {hi, lo}); end
`ifdef MULDIV_DIVZERO_EN
        n_tests++; if (div0 !== 1'b1) begin n_fail++; $display("FAIL div0_flag: got %b want 1", div0); end
`endif
        issue(OP_DIV, 1'b1, 32'hFFFFFFF0, 32'd0);
        wait_idle(cyc);
        n_tests++; if ({hi, lo} !== 64'hFFFFFFF0_FFFFFFFF) begin
            n_fail++; $display("FAIL div0_s: got %h want FFFFFFF0FFFFFFFF", {hi, lo}); end
    endtask

    task automatic test_reset_mid_div;
        issue(OP_DIV, 1'b0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_tests++; if ({hi, lo} !== 64'h0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_div: got %h busy=%b want 0 0", {hi, lo}, busy); end
`ifdef MULDIV_DIVZERO_EN
        n_tests++; if (div0 !== 1'b0) begin n_fail++; $display("FAIL reset_div0_clear: got %b want 0", div0); end
`endif
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_tests++; if ({hi, lo} !== 64'h0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_discard: got %h busy=%b want 0 0", {hi, lo}, busy); end
    endtask

    task automatic test_back_to_back;
        issue(OP_DIV, 1'b0, 32'd5, 32'd0);
        wait_idle(cyc);
        issue(OP_DIV, 1'b0, 32'd100, 32'd7);
        en = 1'b1; op = OP_MTLO; a = 32'hDEAD;
        @(posedge clk); #1;
        op = OP_MUL; a = 32'd5; b = 32'd5;
        @(posedge clk); #1;
        en = 1'b0;
        wait_idle(cyc);
        n_tests++; if (cyc !== 31) begin n_fail++; $display("FAIL ignore_busy_cycles: got %0d want 31", cyc); end
        n_tests++; if ({hi, lo} !== 64'h00000002_0000000E) begin
            n_fail++; $display("FAIL ignore_result: got %h want 000000020000000E", {hi, lo}); end
`ifdef MULDIV_DIVZERO_EN
        n_tests++; if (div0 !== 1'b0) begin n_fail++; $display("FAIL div0_clear_by_div: got %b want 0", div0); end
`endif
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0 || lo !== 32'h0000000E) begin
            n_fail++; $display("FAIL no_queue: got busy=%b lo=%h want 0 0000000E", busy, lo); end
        issue(OP_MUL, 1'b0, 32'd6, 32'd7);
        wait_idle(cyc);
        n_tests++; if ({hi, lo} !== 64'h00000000_0000002A || cyc !== 1) begin
            n_fail++; $display("FAIL b2b_mul: got %h cyc=%0d want 000000000000002A 1", {hi, lo}, cyc); end
    endtask

    task automatic test_reserved;
        issue(3'd6, 1'b0, 32'h11111111, 32'h2);
        n_tests++; if (busy !== 1'b0 || {hi, lo} !== 64'h00000000_0000002A) begin
            n_fail++; $display("FAIL rsv6: got %h busy=%b want 000000000000002A 0", {hi, lo}, busy); end
        issue(3'd7, 1'b1, 32'h22222222, 32'h3);
        @(posedge clk); #1;
        n_tests++; if (busy !== 1'b0 || {hi, lo} !== 64'h00000000_0000002A) begin
            n_fail++; $display("FAIL rsv7: got %h busy=%b want 000000000000002A 0", {hi, lo}, busy); end
    endtask

    task automatic test_lat3;
        @(negedge clk);
        en2 = 1'b1; op2 = OP_MUL; sgn2 = 1'b0; a2 = 16'hFFFF; b2 = 16'hFFFF;
        @(posedge clk); #1;
        en2 = 1'b0; a2 = 16'h0; b2 = 16'h0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            n_tests++; if (busy2 !== 1'b1 || {hi2, lo2} !== 32'h0) begin
                n_fail++; $display("FAIL lat3_edge%0d: got %h busy=%b want 00000000 1", k, {hi2, lo2}, busy2); end
        end
        @(posedge clk); #1;
        n_tests++; if ({hi2, lo2} !== 32'hFFFE0001 || busy2 !== 1'b0) begin
            n_fail++; $display("FAIL lat3_result: got %h busy=%b want FFFE0001 0", {hi2, lo2}, busy2); end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_madd_msub;
        test_div;
        test_divzero;
        test_reset_mid_div;
        test_back_to_back;
        test_reserved;
        test_lat3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
